// File: rtl/sensor_stack_downlink_arbiter.sv
// Arbitrates the Geiger and magnetometer stacks onto one byte-wide downlink.
// Each source debounces new stacks into a one-deep pending buffer; the winner is serialized LSB byte first.

module ssda_stack_detect #(
  parameter int W             = 80,
  parameter int STABLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] stack,
  input  logic         clr,
  output logic         pend,
  output logic [W-1:0] pbuf,
  output logic [7:0]   drop_cnt
);
  localparam int RW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [RW-1:0] RMAX = RW'(STABLE_CYCLES);

  logic [W-1:0]  samp_q, samp_d, shadow_q, shadow_d, buf_q, buf_d;
  logic [RW-1:0] run_q, run_d;
  logic          pend_q, pend_d, accept, drop;
  logic [7:0]    cnt_q, cnt_d;

  always_comb begin
    samp_d = stack;
    // run length counts the incoming sample; saturates once stable enough
    if (stack == samp_q) run_d = (run_q == RMAX) ? run_q : run_q + 1'b1;
    else                 run_d = RW'(1);
    accept   = (run_d >= RMAX) && (|stack) && (stack != shadow_q);
    shadow_d = accept ? stack : shadow_q;
    buf_d    = accept ? stack : buf_q;
    // a same-cycle load of this source consumes the old flag, so no drop
    drop     = accept && pend_q && !clr;
    pend_d   = accept || (pend_q && !clr);
    cnt_d    = (drop && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q   <= '0;
      shadow_q <= '0;
      buf_q    <= '0;
      run_q    <= '0;
      pend_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      samp_q   <= samp_d;
      shadow_q <= shadow_d;
      buf_q    <= buf_d;
      run_q    <= run_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pend     = pend_q;
  assign pbuf     = buf_q;
  assign drop_cnt = cnt_q;
endmodule

module sensor_stack_downlink_arbiter #(
  parameter int N_BYTES       = 10,
  parameter int STABLE_CYCLES = 2,
  parameter int GAP_CYCLES    = 4,
  parameter bit G_PRIORITY    = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 ENABLE,
  input  logic [8*N_BYTES-1:0] G_DATA_STACK,
  input  logic [8*N_BYTES-1:0] M_DATA_STACK,
  output logic [7:0]           TX_DATA,
  output logic                 TX_VALID,
  input  logic                 TX_READY,
  output logic                 SRC_SEL,
  output logic                 BUSY,
  output logic                 PKT_DONE,
  output logic [7:0]           G_DROP_CNT,
  output logic [7:0]           M_DROP_CNT
);
  localparam int W     = 8 * N_BYTES;
  localparam int IW    = (N_BYTES < 2) ? 1 : $clog2(N_BYTES);
  localparam int GW    = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam int GLAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  logic [1:0][W-1:0] stacks, bufs;
  logic [1:0][7:0]   drops;
  logic [1:0]        pend, clr;

  assign stacks = {M_DATA_STACK, G_DATA_STACK};

  for (genvar s = 0; s < 2; s++) begin : g_src
    ssda_stack_detect #(.W(W), .STABLE_CYCLES(STABLE_CYCLES)) u_det (
      .clk(CLK), .rst_n(RESET), .stack(stacks[s]), .clr(clr[s]),
      .pend(pend[s]), .pbuf(bufs[s]), .drop_cnt(drops[s])
    );
  end

  state_t        state_q, state_d;
  logic          win_q, win_d, last_q, last_d, src_q, src_d, win_c, done;
  logic [W-1:0]  sreg_q, sreg_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    src_d   = src_q;
    sreg_d  = sreg_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    clr     = '0;
    done    = 1'b0;
    // 0 = Geiger, 1 = mag; round-robin ties favour whoever was not served last
    if (pend[0] && !pend[1])      win_c = 1'b0;
    else if (!pend[0] && pend[1]) win_c = 1'b1;
    else                          win_c = G_PRIORITY ? 1'b0 : ~last_q;
    case (state_q)
      IDLE: if (ENABLE && (|pend)) begin
        win_d   = win_c;
        state_d = LOAD;
      end
      LOAD: begin
        sreg_d     = bufs[win_q];
        clr[win_q] = 1'b1;
        src_d      = win_q;
        last_d     = win_q;
        idx_d      = '0;
        state_d    = SEND;
      end
      SEND: if (TX_READY) begin
        sreg_d = sreg_q >> 8;
        if (idx_q == IW'(N_BYTES - 1)) begin
          done    = 1'b1;
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      GAP: if (gap_q == GW'(GLAST)) state_d = IDLE;
           else                     gap_d   = gap_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      src_q   <= 1'b0;
      sreg_q  <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      src_q   <= src_d;
      sreg_q  <= sreg_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
    end
  end

  assign TX_VALID   = (state_q == SEND);
  assign TX_DATA    = TX_VALID ? sreg_q[7:0] : 8'h00;
  assign PKT_DONE   = done;
  assign BUSY       = (state_q != IDLE);
  assign SRC_SEL    = src_q;
  assign G_DROP_CNT = drops[0];
  assign M_DROP_CNT = drops[1];
endmodule

// File: tb/tb_sensor_stack_downlink_arbiter.sv
// Directed bench for sensor_stack_downlink_arbiter: packet bytes, ordering, gap, stall, drops, reset.
module tb_sensor_stack_downlink_arbiter;
  logic        CLK = 1'b0, RESET = 1'b0, ENABLE = 1'b1, TX_READY = 1'b1;
  logic [79:0] G_DATA_STACK = '0, M_DATA_STACK = '0;
  logic [7:0]  TX_DATA, G_DROP_CNT, M_DROP_CNT;
  logic        TX_VALID, SRC_SEL, BUSY, PKT_DONE;

  sensor_stack_downlink_arbiter dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE),
    .G_DATA_STACK(G_DATA_STACK), .M_DATA_STACK(M_DATA_STACK),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .SRC_SEL(SRC_SEL), .BUSY(BUSY), .PKT_DONE(PKT_DONE),
    .G_DROP_CNT(G_DROP_CNT), .M_DROP_CNT(M_DROP_CNT)
  );

  always #5 CLK = ~CLK;

  localparam logic [79:0] G1 = 80'hAAAAAAAA_0001_123456_47;
  localparam logic [79:0] G2 = 80'h11223344556677889947;
  localparam logic [79:0] M1 = 80'h0102030405060708094D;
  localparam logic [79:0] G3 = 80'h2233445566778899AA47;
  localparam logic [79:0] M2 = 80'h00000000000000005A4D;
  localparam logic [79:0] M3 = 80'h0000000000000000664D;
  localparam logic [79:0] M4 = 80'h0000000000000000774D;
  localparam logic [79:0] G4 = 80'h0F0E0D0C0B0A09080747;
  localparam logic [79:0] M5 = 80'h9988776655443322114D;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, n_valid = 0, n_done = 0, gap_run = 0, last_gap = 0, vstart = 0;
  logic [7:0] rx[$];
  logic       srcs[$];

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Transfers are predicted on the negedge before the edge that commits them.
  always @(negedge CLK) if (RESET) begin
    if (TX_VALID) begin
      if (gap_run > 0) begin
        last_gap <= gap_run;
        vstart   <= cyc;
      end
      gap_run <= 0;
      n_valid <= n_valid + 1;
      if (TX_READY) begin
        rx.push_back(TX_DATA);
        srcs.push_back(SRC_SEL);
      end
    end else begin
      gap_run <= gap_run + 1;
    end
    if (PKT_DONE) n_done <= n_done + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_done(input string tag, input int target);
    int b = 0;
    while (n_done < target && b < 300) begin tick(1); b++; end
    chk(tag, 80'(n_done), 80'(target));
  endtask

  task automatic wait_rx(input string tag, input int target);
    int b = 0;
    while (rx.size() < target && b < 300) begin tick(1); b++; end
    chk(tag, 80'(rx.size()), 80'(target));
  endtask

  task automatic chk_pkt(input string tag, input int base, input logic [79:0] exp, input logic src);
    if (rx.size() < base + 10) chk({tag, "_len"}, 80'(rx.size()), 80'(base + 10));
    else for (int i = 0; i < 10; i++) begin
      chk({tag, "_byte"}, 80'(rx[base+i]), 80'(exp[8*i +: 8]));
      chk({tag, "_src"}, 80'(srcs[base+i]), 80'(src));
    end
  endtask

  initial begin
    int t0, nv, nd, b;
    logic [7:0] hold;
    // reset state
    #1;
    chk("rst_valid", 80'(TX_VALID), 80'(0));
    chk("rst_busy", 80'(BUSY), 80'(0));
    chk("rst_gdrop", 80'(G_DROP_CNT), 80'(0));
    chk("rst_mdrop", 80'(M_DROP_CNT), 80'(0));
    tick(2);
    RESET = 1'b1;
    tick(50);
    chk("zero_stacks_valid", 80'(n_valid), 80'(0));
    chk("zero_stacks_mdrop", 80'(M_DROP_CNT), 80'(0));

    // single Geiger packet
    G_DATA_STACK = G1;
    t0 = cyc;
    wait_done("g1_done", 1);
    tick(2);
    chk_pkt("g1", 0, G1, 1'b0);
    chk("g1_latency", 80'(vstart - t0), 80'(4));
    chk("g1_count", 80'(rx.size()), 80'(10));

    // one-cycle glitch on mag is never accepted
    M_DATA_STACK = M2; tick(1); M_DATA_STACK = '0; tick(20);
    chk("glitch_none", 80'(rx.size()), 80'(10));

    // simultaneous change: Geiger first, then mag after gap
    rx.delete(); srcs.delete();
    G_DATA_STACK = G2; M_DATA_STACK = M1;
    wait_done("pair_done", 3);
    tick(2);
    chk_pkt("pair_g", 0, G2, 1'b0);
    chk_pkt("pair_m", 10, M1, 1'b1);
    chk("pair_gap", 80'(last_gap), 80'(6));
    chk("pair_gdrop", 80'(G_DROP_CNT), 80'(0));
    chk("pair_mdrop", 80'(M_DROP_CNT), 80'(0));

    // mag churn while a Geiger packet is stalled in flight
    rx.delete(); srcs.delete();
    G_DATA_STACK = G3;
    b = 0;
    while (!TX_VALID && b < 50) begin tick(1); b++; end
    chk("churn_start", 80'(TX_VALID), 80'(1));
    TX_READY = 1'b0;
    M_DATA_STACK = M2; tick(1);
    M_DATA_STACK = M3; tick(3);
    M_DATA_STACK = M4; tick(5);
    TX_READY = 1'b1;
    wait_done("churn_done", 5);
    tick(2);
    chk_pkt("churn_g", 0, G3, 1'b0);
    chk_pkt("churn_m", 10, M4, 1'b1);
    chk("churn_total", 80'(rx.size()), 80'(20));
    chk("churn_mdrop", 80'(M_DROP_CNT), 80'(1));
    chk("churn_gdrop", 80'(G_DROP_CNT), 80'(0));

    // back-pressure at byte 3
    rx.delete(); srcs.delete();
    G_DATA_STACK = G4;
    wait_rx("stall_reach", 3);
    TX_READY = 1'b0;
    hold = G4[31:24];
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      chk("stall_data", 80'(TX_DATA), 80'(hold));
      chk("stall_valid", 80'(TX_VALID), 80'(1));
    end
    tick(1);
    TX_READY = 1'b1;
    wait_done("stall_done", 6);
    tick(2);
    chk_pkt("stall", 0, G4, 1'b0);
    chk("stall_total", 80'(rx.size()), 80'(10));

    // reset in the middle of a mag packet
    rx.delete(); srcs.delete();
    M_DATA_STACK = M5;
    wait_rx("rst_reach", 5);
    chk("pre_rst_src", 80'(SRC_SEL), 80'(1));
    #2;
    RESET = 1'b0; G_DATA_STACK = '0; M_DATA_STACK = '0;
    #1;
    chk("mid_rst_valid", 80'(TX_VALID), 80'(0));
    chk("mid_rst_data", 80'(TX_DATA), 80'(0));
    chk("mid_rst_src", 80'(SRC_SEL), 80'(0));
    chk("mid_rst_busy", 80'(BUSY), 80'(0));
    chk("mid_rst_mdrop", 80'(M_DROP_CNT), 80'(0));
    tick(3);
    RESET = 1'b1;
    nv = n_valid; nd = n_done;
    tick(30);
    chk("post_rst_valid", 80'(n_valid - nv), 80'(0));
    chk("post_rst_done", 80'(n_done - nd), 80'(0));
    chk("post_rst_busy", 80'(BUSY), 80'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
